// File: rtl/uart_pkg.sv
// Shared encodings for the UART frame path: FSM states, error codes, default header.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

endpackage

// File: rtl/uart_byte_edge.sv
// Turns the receiver's byte-valid level into a single-cycle accept strobe.
module uart_byte_edge
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_byte_stb_c,
  output logic [BYTE_W-1:0] o_byte_c
);

  logic r_rv_q;

  // Resets high so a level already asserted at reset release is not taken as a new byte.
  always_ff @(posedge clk) begin
    if (!rst) r_rv_q <= 1'b1;
    else      r_rv_q <= i_rx_valid;
  end

  assign o_byte_stb_c = i_rx_valid & ~r_rv_q;
  // Receiver holds the byte stable while valid is high, so it is valid on the strobe edge.
  assign o_byte_c     = i_rx_data;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles HEADER/LEN/PAYLOAD/CHECKSUM frames from received bytes and publishes
// each validated payload as one parallel word with a single-cycle strobe.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0]  HEADER         = DEFAULT_HEADER,
  parameter int unsigned MAX_LEN        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [8*MAX_LEN-1:0]         frame_data,
  output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
  output logic                         frame_valid,
  output logic                         frame_err,
  output logic [1:0]                   err_code
);

  localparam int unsigned DATA_W = 8 * MAX_LEN;
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic              w_stb;
  logic [BYTE_W-1:0] w_byte;

  uart_byte_edge u_byte_edge (
    .clk          (clk),
    .rst          (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_byte_stb_c (w_stb),
    .o_byte_c     (w_byte)
  );

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [7:0]        r_sum;
  logic [DATA_W-1:0] r_shadow;
  logic [TMO_W-1:0]  r_tmo;
  err_code_t         r_code;

  logic [LEN_W-1:0]  w_len_nxt;
  logic [LEN_W-1:0]  w_idx_nxt;
  logic [7:0]        w_sum_nxt;
  logic [DATA_W-1:0] w_shadow_nxt;
  logic [TMO_W-1:0]  w_tmo_nxt;
  err_code_t         w_code_nxt;
  logic [DATA_W-1:0] w_fdata_nxt;
  logic [LEN_W-1:0]  w_flen_nxt;
  logic              w_fv_nxt;
  logic              w_fe_nxt;

  logic w_len_ok;
  logic w_last;
  logic w_tmo_fire;

  assign w_len_ok   = (w_byte != 8'd0) && (w_byte <= 8'(MAX_LEN));
  assign w_last     = (LEN_W'(r_idx + LEN_W'(1)) == r_len);
  // An accepted byte on the expiry cycle takes priority over the timeout.
  assign w_tmo_fire = (r_state != S_IDLE) && !w_stb &&
                      (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_stb && (w_byte == HEADER)) w_state_nxt = S_LEN;
      S_LEN:     if (w_stb) w_state_nxt = w_len_ok ? S_PAYLOAD : S_IDLE;
      S_PAYLOAD: if (w_stb && w_last) w_state_nxt = S_CHECK;
      S_CHECK:   if (w_stb) w_state_nxt = S_IDLE;
    endcase
    if (w_tmo_fire) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_len_nxt    = r_len;
    w_idx_nxt    = r_idx;
    w_sum_nxt    = r_sum;
    w_shadow_nxt = r_shadow;
    w_code_nxt   = r_code;
    w_fdata_nxt  = frame_data;
    w_flen_nxt   = frame_len;
    w_fv_nxt     = 1'b0;
    w_fe_nxt     = 1'b0;

    if ((r_state == S_IDLE) || w_stb || w_tmo_fire) w_tmo_nxt = '0;
    else                                            w_tmo_nxt = r_tmo + TMO_W'(1);

    if (w_stb) begin
      unique case (r_state)
        S_IDLE: ;
        S_LEN: begin
          if (w_len_ok) begin
            w_len_nxt    = LEN_W'(w_byte);
            w_sum_nxt    = w_byte;
            w_idx_nxt    = '0;
            w_shadow_nxt = '0;
          end else begin
            w_fe_nxt   = 1'b1;
            w_code_nxt = ERR_LEN;
          end
        end
        S_PAYLOAD: begin
          for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (r_idx == LEN_W'(i)) w_shadow_nxt[8*i +: 8] = w_byte;
          end
          w_sum_nxt = r_sum + w_byte;
          w_idx_nxt = r_idx + LEN_W'(1);
        end
        S_CHECK: begin
          if (w_byte == r_sum) begin
            w_fv_nxt    = 1'b1;
            w_fdata_nxt = r_shadow;
            w_flen_nxt  = r_len;
          end else begin
            w_fe_nxt   = 1'b1;
            w_code_nxt = ERR_CSUM;
          end
        end
      endcase
    end

    if (w_tmo_fire) begin
      w_fe_nxt   = 1'b1;
      w_code_nxt = ERR_TIMEOUT;
    end
  end

  // Reset mid-frame simply clears everything; no error pulse is generated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len       <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_shadow    <= '0;
      r_tmo       <= '0;
      r_code      <= ERR_NONE;
      frame_data  <= '0;
      frame_len   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
      r_sum       <= w_sum_nxt;
      r_shadow    <= w_shadow_nxt;
      r_tmo       <= w_tmo_nxt;
      r_code      <= w_code_nxt;
      frame_data  <= w_fdata_nxt;
      frame_len   <= w_flen_nxt;
      frame_valid <= w_fv_nxt;
      frame_err   <= w_fe_nxt;
    end
  end

  assign err_code = r_code;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good/bad frames, length limits, timeout, level-held valid, reset.
module tb_uart_frame_parser;

  localparam int unsigned TMO = 10000;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] frame_data;
  logic [2:0]  frame_len;
  logic        frame_valid;
  logic        frame_err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  int nfv = 0;
  int nfe = 0;
  int nboth = 0;

  uart_frame_parser #(
    .HEADER         (8'hA5),
    .MAX_LEN        (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_data  (frame_data),
    .frame_len   (frame_len),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) nfv++;
    if (frame_err) nfe++;
    if (frame_valid && frame_err) nboth++;
  end

  // Rising edge at the next clock, outputs sampled #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, output logic fv, output logic fe);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    fv = frame_valid;
    fe = frame_err;
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_hold(input logic [7:0] b, input int hold, output logic fv);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    fv = frame_valid;
    repeat (hold - 1) @(posedge clk);
    #1 rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic fv, fe;
    int v0, e0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset();
    checks++; if (frame_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp %h", frame_data, 32'h0); end
    checks++; if (frame_len !== 3'd0) begin errors++; $display("FAIL rst_len got %0d exp 0", frame_len); end
    checks++; if ({frame_valid, frame_err} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b exp 00", {frame_valid, frame_err}); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rst_code got %0d exp 0", err_code); end
    // Header held high across reset release must not be accepted.
    v0 = nfv; e0 = nfe;
    rst = 1'b0; rx_data = 8'hA5; rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_valid = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h01, fv, fe);
    send_byte(8'h7E, fv, fe);
    send_byte(8'h7F, fv, fe);
    checks++; if ((nfv - v0) !== 0 || (nfe - e0) !== 0) begin errors++; $display("FAIL rst_level_hdr got fv=%0d fe=%0d exp 0 0", nfv - v0, nfe - e0); end
  endtask

  task automatic test_good_frame();
    logic fv, fe;
    int v0, e0;
    v0 = nfv; e0 = nfe;
    send_byte(8'h00, fv, fe);
    send_byte(8'h7E, fv, fe);
    send_byte(8'hA5, fv, fe);
    send_byte(8'h02, fv, fe);
    send_byte(8'h11, fv, fe);
    send_byte(8'h22, fv, fe);
    send_byte(8'h35, fv, fe);
    checks++; if (fv !== 1'b1) begin errors++; $display("FAIL good_pulse_timing got %b exp 1", fv); end
    checks++; if (frame_data !== 32'h0000_2211) begin errors++; $display("FAIL good_data got %h exp %h", frame_data, 32'h0000_2211); end
    checks++; if (frame_len !== 3'd2) begin errors++; $display("FAIL good_len got %0d exp 2", frame_len); end
    checks++; if ((nfv - v0) !== 1 || (nfe - e0) !== 0) begin errors++; $display("FAIL good_counts got fv=%0d fe=%0d exp 1 0", nfv - v0, nfe - e0); end
  endtask

  task automatic test_bad_csum();
    logic fv, fe;
    int v0;
    v0 = nfv;
    send_byte(8'hA5, fv, fe);
    send_byte(8'h02, fv, fe);
    send_byte(8'h11, fv, fe);
    send_byte(8'h22, fv, fe);
    send_byte(8'h36, fv, fe);
    checks++; if (fe !== 1'b1) begin errors++; $display("FAIL csum_pulse got %b exp 1", fe); end
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL csum_code got %0d exp 2", err_code); end
    checks++; if (frame_data !== 32'h0000_2211 || frame_len !== 3'd2) begin errors++; $display("FAIL csum_hold got %h/%0d exp 00002211/2", frame_data, frame_len); end
    checks++; if ((nfv - v0) !== 0) begin errors++; $display("FAIL csum_no_valid got %0d exp 0", nfv - v0); end
  endtask

  task automatic test_bad_len();
    logic fv, fe;
    send_byte(8'hA5, fv, fe);
    send_byte(8'h00, fv, fe);
    checks++; if (fe !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL len0 got fe=%b code=%0d exp 1 1", fe, err_code); end
    send_byte(8'hA5, fv, fe);
    send_byte(8'h05, fv, fe);
    checks++; if (fe !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL len5 got fe=%b code=%0d exp 1 1", fe, err_code); end
    send_byte(8'hA5, fv, fe);
    send_byte(8'h01, fv, fe);
    send_byte(8'h7E, fv, fe);
    send_byte(8'h7F, fv, fe);
    checks++; if (fv !== 1'b1 || frame_data !== 32'h7E || frame_len !== 3'd1) begin errors++; $display("FAIL len_recover got fv=%b %h/%0d exp 1 0000007e/1", fv, frame_data, frame_len); end
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL code_holds got %0d exp 1", err_code); end
  endtask

  task automatic test_max_and_header_data();
    logic fv, fe;
    send_byte(8'hA5, fv, fe);
    send_byte(8'h04, fv, fe);
    send_byte(8'h01, fv, fe);
    send_byte(8'h02, fv, fe);
    send_byte(8'h03, fv, fe);
    send_byte(8'h04, fv, fe);
    send_byte(8'h0E, fv, fe);
    checks++; if (fv !== 1'b1 || frame_data !== 32'h0403_0201 || frame_len !== 3'd4) begin errors++; $display("FAIL max_len got fv=%b %h/%0d exp 1 04030201/4", fv, frame_data, frame_len); end
    send_byte(8'hA5, fv, fe);
    send_byte(8'h03, fv, fe);
    send_byte(8'hA5, fv, fe);
    send_byte(8'h01, fv, fe);
    send_byte(8'h02, fv, fe);
    send_byte(8'hAB, fv, fe);
    checks++; if (fv !== 1'b1 || frame_data !== 32'h0002_01A5 || frame_len !== 3'd3) begin errors++; $display("FAIL hdr_as_data got fv=%b %h/%0d exp 1 000201a5/3", fv, frame_data, frame_len); end
  endtask

  task automatic test_timeout();
    logic fv, fe;
    int v0;
    send_byte(8'hA5, fv, fe);
    send_byte(8'h01, fv, fe);
    repeat (TMO - 2) @(posedge clk);
    #1;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL tmo_early got %b exp 0", frame_err); end
    @(posedge clk); #1;
    checks++; if (frame_err !== 1'b1 || err_code !== 2'd3) begin errors++; $display("FAIL tmo_fire got fe=%b code=%0d exp 1 3", frame_err, err_code); end
    @(posedge clk); #1;
    checks++; if (frame_err !== 1'b0 || frame_data !== 32'h0002_01A5) begin errors++; $display("FAIL tmo_after got fe=%b %h exp 0 000201a5", frame_err, frame_data); end
    // Byte accepted on the expiry cycle wins over the timeout.
    v0 = nfe;
    send_byte(8'hA5, fv, fe);
    send_byte(8'h01, fv, fe);
    repeat (TMO - 2) @(posedge clk);
    #1 rx_data = 8'h10; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h11, fv, fe);
    checks++; if ((nfe - v0) !== 0 || fv !== 1'b1 || frame_data !== 32'h10) begin errors++; $display("FAIL tmo_suppress got fe_cnt=%0d fv=%b %h exp 0 1 00000010", nfe - v0, fv, frame_data); end
  endtask

  task automatic test_level_hold();
    logic fv;
    int v0, e0;
    v0 = nfv; e0 = nfe;
    send_hold(8'hA5, 7776, fv);
    send_hold(8'h01, 7776, fv);
    send_hold(8'hFF, 7776, fv);
    send_hold(8'h00, 7776, fv);
    checks++; if (fv !== 1'b1 || frame_data !== 32'hFF || frame_len !== 3'd1) begin errors++; $display("FAIL hold_frame got fv=%b %h/%0d exp 1 000000ff/1", fv, frame_data, frame_len); end
    checks++; if ((nfv - v0) !== 1 || (nfe - e0) !== 0) begin errors++; $display("FAIL hold_counts got fv=%0d fe=%0d exp 1 0", nfv - v0, nfe - e0); end
  endtask

  task automatic test_reset_mid_frame();
    logic fv, fe;
    int v0, e0;
    v0 = nfv; e0 = nfe;
    send_byte(8'hA5, fv, fe);
    send_byte(8'h02, fv, fe);
    send_byte(8'h11, fv, fe);
    do_reset();
    checks++; if (frame_data !== 32'h0 || frame_len !== 3'd0 || err_code !== 2'd0) begin errors++; $display("FAIL midrst_clear got %h/%0d code=%0d exp 0/0 0", frame_data, frame_len, err_code); end
    send_byte(8'hA5, fv, fe);
    send_byte(8'h01, fv, fe);
    send_byte(8'h42, fv, fe);
    send_byte(8'h43, fv, fe);
    checks++; if (fv !== 1'b1 || frame_data !== 32'h42 || frame_len !== 3'd1) begin errors++; $display("FAIL midrst_frame got fv=%b %h/%0d exp 1 00000042/1", fv, frame_data, frame_len); end
    checks++; if ((nfv - v0) !== 1 || (nfe - e0) !== 0) begin errors++; $display("FAIL midrst_counts got fv=%0d fe=%0d exp 1 0", nfv - v0, nfe - e0); end
  endtask

  initial begin
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_max_and_header_data();
    test_timeout();
    test_level_hold();
    test_reset_mid_frame();
    checks++; if (nboth !== 0) begin errors++; $display("FAIL both_pulses got %0d exp 0", nboth); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
